pc_sequencer: RTL

- Upstream neighbour of the fetch stage in cpu15.
- Owns the program counter P_COUNT and generates the four phase strobes CLK_FT, CLK_DC, CLK_EX and CLK_WB from one system clock.
- Resolves jmp (1100), je (1011) and hlt (1111) at the end of each instruction and drives the next P_COUNT into fetch.
- One instruction takes exactly 4 system clocks.

---
 rtl/cpu15_pkg.sv | 22 ++
 rtl/pc_sequencer.sv | 97 +++++++++
 2 files changed

// File: rtl/cpu15_pkg.sv
// Shared cpu15 definitions: opcode constants, sequencer state encoding and PC width default.
package cpu15_pkg;

    localparam int unsigned DefaultPcWidth = 8;

    localparam logic [3:0] OP_MOV = 4'b0000;
    localparam logic [3:0] OP_JE  = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LD  = 4'b1101;
    localparam logic [3:0] OP_ST  = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        StIdle,
        StFt,
        StDc,
        StEx,
        StWb,
        StHalt
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer.sv
// cpu15 program counter and four-phase strobe sequencer; one instruction every four clocks,
// branches and halt resolved on the edge leaving writeback.
module pc_sequencer
    import cpu15_pkg::*;
#(
    parameter int unsigned          PC_WIDTH = DefaultPcWidth,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                CLK,
    input  logic                N_RESET,
    input  logic                RUN,
    input  logic                STEP_MODE,
    input  logic [3:0]          OP_CODE,
    input  logic [7:0]          OP_DATA,
    input  logic                CMP_FLAG,
    output logic [PC_WIDTH-1:0] P_COUNT,
    output logic                CLK_FT,
    output logic                CLK_DC,
    output logic                CLK_EX,
    output logic                CLK_WB,
    output logic                HALTED
);

    seq_state_e          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                ft_q, dc_q, ex_q, wb_q, halted_q;

    function automatic logic [PC_WIDTH-1:0] next_pc(
        input logic [3:0]          op,
        input logic [7:0]          data,
        input logic                cmp,
        input logic [PC_WIDTH-1:0] pc
    );
        logic [PC_WIDTH-1:0] target;
        logic [PC_WIDTH-1:0] inc;
        target = PC_WIDTH'(data);
        inc    = pc + PC_WIDTH'(1);
        unique case (op)
            OP_JMP:  next_pc = target;
            OP_JE:   next_pc = cmp ? target : inc;
            OP_HLT:  next_pc = pc;
            default: next_pc = inc;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            StIdle: if (RUN) state_d = StFt;
            StFt:   state_d = StDc;
            StDc:   state_d = StEx;
            StEx:   state_d = StWb;
            StWb: begin
                pc_d = next_pc(OP_CODE, OP_DATA, CMP_FLAG, pc_q);
                if (OP_CODE == OP_HLT) begin
                    state_d = StHalt;
                end else if (STEP_MODE) begin
                    state_d = StIdle;
                end else begin
                    state_d = StFt;
                end
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    // Strobes are flops loaded from the next state so each output is a clean registered pulse.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            ft_q     <= 1'b0;
            dc_q     <= 1'b0;
            ex_q     <= 1'b0;
            wb_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ft_q     <= (state_d == StFt);
            dc_q     <= (state_d == StDc);
            ex_q     <= (state_d == StEx);
            wb_q     <= (state_d == StWb);
            halted_q <= (state_d == StHalt);
        end
    end

    assign P_COUNT = pc_q;
    assign CLK_FT  = ft_q;
    assign CLK_DC  = dc_q;
    assign CLK_EX  = ex_q;
    assign CLK_WB  = wb_q;
    assign HALTED  = halted_q;

endmodule
